sync_fifo_flags: RTL

Parametrised single-clock FIFO, the next generation of the team's basic FIFO. Adds programmable almost-full/almost-empty thresholds, fill-level output, a synchronous flush, overflow/underflow error pulses, and a selectable first-word-fall-through read mode. Used as the general buffering element between streaming sub-blocks in one clock domain.

---
 rtl/sync_fifo_flags.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, a fill-level output, a synchronous flush, overflow/underflow
// pulses, and a choice of registered or first-word-fall-through read.
module sync_fifo_flags #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       pop_valid,
    output logic                       empty,
    output logic                       almost_empty,
    output logic                       underflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;

    // Flags are pure decodes of the registered occupancy.
    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == LW'(DEPTH));
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_level >= LW'(AFULL_THRESH));
    assign almost_empty = (r_level <= LW'(AEMPTY_THRESH));
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A push into a full FIFO is only legal when a pop frees the slot this cycle.
    assign w_pop_ok  = pop && !w_empty;
    assign w_push_ok = push && (!w_full || w_pop_ok);

    // Storage write; the array carries no reset so it can map onto RAM.
    // NOTE: memories are deliberately left out of the reset; an empty FIFO never reads stale words.
    always_ff @(posedge clk) begin
        if (!clr && w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and error pulses; flush wins over push/pop.
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= push && !w_push_ok;
            r_underflow <= pop && !w_pop_ok;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [WIDTH-1:0] r_pop_data;
            logic             r_pop_valid;

            // Registered read: data and a one-cycle valid follow each accepted pop.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pop_data  <= '0;
                    r_pop_valid <= 1'b0;
                end else if (clr) begin
                    r_pop_valid <= 1'b0;
                end else begin
                    r_pop_valid <= w_pop_ok;
                    if (w_pop_ok) begin
                        r_pop_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign pop_data  = r_pop_data;
            assign pop_valid = r_pop_valid;
        end else begin : g_fwft
            // Head of queue is always presented; pop only acknowledges it.
            assign pop_data  = r_mem[r_rd_ptr];
            assign pop_valid = !w_empty;
        end
    endgenerate

endmodule
